// File: rtl/gt_rx_frame_checker.sv
`default_nettype none
// ============================================================================
// Module   : gt_rx_frame_checker
// Brief    : Checks framed test traffic arriving on a 64-bit receive stream
//            with no tlast. Each frame is a header (magic, seq, len, seed)
//            followed by len generated payload words. Each frame is reported
//            with a one-cycle frame_ok / frame_err pulse, and both outcomes
//            are counted. Define GT_RX_FRAME_CHECKSUM_EN to expect a trailing
//            XOR checksum word after the payload.
// Revision : 1.0 - initial release
// ============================================================================
module gt_rx_frame_checker #(
  parameter logic [15:0] MAGIC   = 16'hA55A,
  parameter int          MAX_LEN = 256,
  parameter int          TIMEOUT = 1024
) (
  input  logic        core_clk,
  input  logic        reset,
  input  logic        channel_up,
  input  logic [63:0] s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [2:0]  err_code,
  output logic [31:0] frame_cnt,
  output logic [15:0] err_cnt,
  output logic        busy
);

  localparam logic [2:0] c_ST_IDLE    = 3'd0;
  localparam logic [2:0] c_ST_HDR     = 3'd1;
  localparam logic [2:0] c_ST_PAYLOAD = 3'd2;
  localparam logic [2:0] c_ST_RESYNC  = 3'd3;
`ifdef GT_RX_FRAME_CHECKSUM_EN
  localparam logic [2:0] c_ST_CSUM    = 3'd4;
  localparam logic [2:0] c_ERR_CSUM   = 3'd5;
`endif

  localparam logic [2:0] c_ERR_NONE    = 3'd0;
  localparam logic [2:0] c_ERR_MAGIC   = 3'd1;
  localparam logic [2:0] c_ERR_LEN     = 3'd2;
  localparam logic [2:0] c_ERR_SEQ     = 3'd3;
  localparam logic [2:0] c_ERR_DATA    = 3'd4;
  localparam logic [2:0] c_ERR_TIMEOUT = 3'd6;
  localparam logic [2:0] c_ERR_LINK    = 3'd7;

  localparam int c_TO_W = $clog2(TIMEOUT + 1);

  logic [1:0]        r_rst_pipe;
  logic              w_rst;
  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [15:0]       r_seq;
  logic [15:0]       r_len;
  logic [15:0]       r_seed;
  logic [15:0]       r_idx;
  logic [15:0]       r_exp_seq;
  logic [2:0]        r_err_lat;
  logic [c_TO_W-1:0] r_idle_cnt;
  logic              r_frame_ok;
  logic              r_frame_err;
  logic [2:0]        r_err_code;
  logic [31:0]       r_frame_cnt;
  logic [15:0]       r_err_cnt;
`ifdef GT_RX_FRAME_CHECKSUM_EN
  logic [63:0]       r_csum;
  logic [2:0]        w_csum_code;
`endif

  logic              w_accept;
  logic              w_magic_ok;
  logic              w_len_bad;
  logic              w_busy;
  logic              w_timeout;
  logic              w_last;
  logic [15:0]       w_hdr_seq;
  logic [15:0]       w_hdr_len;
  logic [63:0]       w_exp_word;
  logic [2:0]        w_pay_code;
  logic              w_hdr_load;
  logic              w_pay_acc;
  logic              w_ok_nxt;
  logic              w_ferr_nxt;
  logic [2:0]        w_code_nxt;

  // Reset asserts immediately but is released only on a core_clk edge
  always_ff @(posedge core_clk or posedge reset) begin
    if (reset) r_rst_pipe <= 2'b11;
    else       r_rst_pipe <= {r_rst_pipe[0], 1'b0};
  end
  assign w_rst = r_rst_pipe[1];

  assign w_accept   = s_tvalid && s_tready;
  assign w_hdr_seq  = s_tdata[47:32];
  assign w_hdr_len  = s_tdata[31:16];
  assign w_magic_ok = (s_tdata[63:48] == MAGIC);
  assign w_len_bad  = (w_hdr_len == 16'd0) || (int'({16'd0, w_hdr_len}) > MAX_LEN);
  assign w_last     = (r_idx == r_len - 16'd1);
  assign w_exp_word = {16'(r_seed + r_idx), r_seq, r_idx, ~r_idx};
  assign w_timeout  = w_busy && !s_tvalid && (r_idle_cnt == c_TO_W'(TIMEOUT - 1));

  // The first error of a frame sticks; a data error counts only if none is held
  assign w_pay_code = (r_err_lat != c_ERR_NONE) ? r_err_lat :
                      ((s_tdata != w_exp_word) ? c_ERR_DATA : c_ERR_NONE);

`ifdef GT_RX_FRAME_CHECKSUM_EN
  assign w_csum_code = (r_err_lat != c_ERR_NONE) ? r_err_lat :
                       ((s_tdata != r_csum) ? c_ERR_CSUM : c_ERR_NONE);
  assign w_busy      = (r_state == c_ST_PAYLOAD) || (r_state == c_ST_CSUM);
`else
  assign w_busy      = (r_state == c_ST_PAYLOAD);
`endif

  // Next state and pulse decode: link loss beats timeout, timeout beats data
  always_comb begin
    w_state_nxt = r_state;
    w_ok_nxt    = 1'b0;
    w_ferr_nxt  = 1'b0;
    w_code_nxt  = c_ERR_NONE;
    w_hdr_load  = 1'b0;
    w_pay_acc   = 1'b0;
    if ((r_state != c_ST_IDLE) && !channel_up) begin
      w_state_nxt = c_ST_IDLE;
      if (w_busy) begin
        w_ferr_nxt = 1'b1;
        w_code_nxt = c_ERR_LINK;
      end
    end else if (w_timeout) begin
      w_state_nxt = c_ST_HDR;
      w_ferr_nxt  = 1'b1;
      w_code_nxt  = c_ERR_TIMEOUT;
    end else begin
      case (r_state)
        c_ST_IDLE: if (channel_up) w_state_nxt = c_ST_HDR;
        c_ST_HDR, c_ST_RESYNC: begin
          if (w_accept) begin
            if (!w_magic_ok) begin
              // While resynchronising, non-magic words are dropped silently
              if (r_state == c_ST_HDR) begin
                w_state_nxt = c_ST_RESYNC;
                w_ferr_nxt  = 1'b1;
                w_code_nxt  = c_ERR_MAGIC;
              end
            end else if (w_len_bad) begin
              w_state_nxt = c_ST_HDR;
              w_ferr_nxt  = 1'b1;
              w_code_nxt  = c_ERR_LEN;
            end else begin
              w_state_nxt = c_ST_PAYLOAD;
              w_hdr_load  = 1'b1;
            end
          end
        end
        c_ST_PAYLOAD: begin
          if (w_accept) begin
            w_pay_acc = 1'b1;
            if (w_last) begin
`ifdef GT_RX_FRAME_CHECKSUM_EN
              w_state_nxt = c_ST_CSUM;
`else
              w_state_nxt = c_ST_HDR;
              w_ok_nxt    = (w_pay_code == c_ERR_NONE);
              w_ferr_nxt  = (w_pay_code != c_ERR_NONE);
              w_code_nxt  = w_pay_code;
`endif
            end
          end
        end
`ifdef GT_RX_FRAME_CHECKSUM_EN
        c_ST_CSUM: begin
          if (w_accept) begin
            w_state_nxt = c_ST_HDR;
            w_ok_nxt    = (w_csum_code == c_ERR_NONE);
            w_ferr_nxt  = (w_csum_code != c_ERR_NONE);
            w_code_nxt  = w_csum_code;
          end
        end
`endif
        default: w_state_nxt = c_ST_IDLE;
      endcase
    end
  end

  // State register, registered pulses and saturating frame counters
  always_ff @(posedge core_clk or posedge w_rst) begin
    if (w_rst) begin
      r_state     <= c_ST_IDLE;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_code  <= c_ERR_NONE;
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_frame_ok  <= w_ok_nxt;
      r_frame_err <= w_ferr_nxt;
      r_err_code  <= w_code_nxt;
      if (w_ok_nxt && (r_frame_cnt != '1)) r_frame_cnt <= r_frame_cnt + 1'b1;
      if (w_ferr_nxt && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  // Per-frame context: header fields, word index, sticky error, running XOR
  always_ff @(posedge core_clk or posedge w_rst) begin
    if (w_rst) begin
      r_seq     <= '0;
      r_len     <= '0;
      r_seed    <= '0;
      r_idx     <= '0;
      r_exp_seq <= '0;
      r_err_lat <= c_ERR_NONE;
`ifdef GT_RX_FRAME_CHECKSUM_EN
      r_csum    <= '0;
`endif
    end else if (w_hdr_load) begin
      r_seq     <= w_hdr_seq;
      r_len     <= w_hdr_len;
      r_seed    <= s_tdata[15:0];
      r_idx     <= '0;
      r_exp_seq <= w_hdr_seq + 16'd1;
      r_err_lat <= (w_hdr_seq != r_exp_seq) ? c_ERR_SEQ : c_ERR_NONE;
`ifdef GT_RX_FRAME_CHECKSUM_EN
      r_csum    <= s_tdata;
`endif
    end else if (w_pay_acc) begin
      r_idx     <= r_idx + 16'd1;
      r_err_lat <= w_pay_code;
`ifdef GT_RX_FRAME_CHECKSUM_EN
      r_csum    <= r_csum ^ s_tdata;
`endif
    end
  end

  // Count consecutive stalled cycles while a frame is open
  always_ff @(posedge core_clk or posedge w_rst) begin
    if (w_rst)                                  r_idle_cnt <= '0;
    else if (w_busy && !s_tvalid && !w_timeout) r_idle_cnt <= r_idle_cnt + 1'b1;
    else                                        r_idle_cnt <= '0;
  end

  assign s_tready  = (r_state != c_ST_IDLE);
  assign busy      = w_busy;
  assign frame_ok  = r_frame_ok;
  assign frame_err = r_frame_err;
  assign err_code  = r_err_code;
  assign frame_cnt = r_frame_cnt;
  assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_gt_rx_frame_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_gt_rx_frame_checker
// Brief    : Self-checking bench for gt_rx_frame_checker. Frames are built as
//            transactions; the expected outcome of each frame is derived from
//            the frame-level rules (first error wins, seq tracking, counters).
//            Honours GT_RX_FRAME_CHECKSUM_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gt_rx_frame_checker;

  localparam logic [15:0] c_MAGIC   = 16'hA55A;
  localparam int          c_MAX_LEN = 256;
  localparam int          c_TIMEOUT = 1024;
`ifdef GT_RX_FRAME_CHECKSUM_EN
  localparam bit c_CSUM_EN = 1'b1;
`else
  localparam bit c_CSUM_EN = 1'b0;
`endif

  logic        core_clk = 1'b0;
  logic        reset = 1'b1;
  logic        channel_up = 1'b0;
  logic [63:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        frame_ok;
  logic        frame_err;
  logic [2:0]  err_code;
  logic [31:0] frame_cnt;
  logic [15:0] err_cnt;
  logic        busy;

  int          n_checks = 0;
  int          n_fail = 0;
  int          pulses_seen = 0;
  int          m_pulses = 0;
  int          m_fcnt = 0;
  int          m_ecnt = 0;
  logic [15:0] m_exp_seq = '0;

  gt_rx_frame_checker #(
    .MAGIC   (c_MAGIC),
    .MAX_LEN (c_MAX_LEN),
    .TIMEOUT (c_TIMEOUT)
  ) u_dut (
    .core_clk   (core_clk),
    .reset      (reset),
    .channel_up (channel_up),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .frame_ok   (frame_ok),
    .frame_err  (frame_err),
    .err_code   (err_code),
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt),
    .busy       (busy)
  );

  always #5 core_clk = ~core_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every pulse is counted; ok and err must never coincide
  always @(negedge core_clk) begin
    if (frame_ok || frame_err) begin
      pulses_seen++;
      check("excl", 64'(frame_ok && frame_err), 64'd0);
    end
  end

  task automatic idle_gap(input int max_gap);
    int n;
    n = $urandom_range(max_gap, 0);
    repeat (n) begin @(posedge core_clk); #1; end
  endtask

  // Present one word and hold it until accepted; returns just after that edge
  task automatic send(input logic [63:0] w);
    int  n;
    logic acc;
    n = 0;
    acc = 1'b0;
    s_tdata  = w;
    s_tvalid = 1'b1;
    while (!acc && n < 100) begin
      @(negedge core_clk);
      acc = s_tready;
      @(posedge core_clk);
      #1;
      n++;
    end
    if (!acc) check("tready_wait", 64'd0, 64'd1);
    s_tvalid = 1'b0;
  endtask

  // Expect a close pulse in the cycle after the last accepted word
  task automatic expect_close(input string tag, input logic [2:0] code);
    if (code == 3'd0) m_fcnt++;
    else              m_ecnt++;
    m_pulses++;
    @(negedge core_clk);
    check(tag, {59'd0, frame_ok, frame_err, err_code},
          {59'd0, code == 3'd0, code != 3'd0, code});
    check({tag, "_fcnt"}, 64'(frame_cnt), 64'(m_fcnt));
    check({tag, "_ecnt"}, 64'(err_cnt), 64'(m_ecnt));
    @(posedge core_clk);
    #1;
  endtask

  // Send a frame; stop_after >= 0 leaves it open after that many payload words
  task automatic send_frame(input string tag, input logic [15:0] seq, input logic [15:0] len,
                            input logic [15:0] seed, input int corrupt_idx,
                            input logic [5:0] corrupt_bit, input bit bad_csum,
                            input int max_gap, input int stop_after);
    logic [63:0] hdr, w, csum;
    logic [15:0] k16;
    logic [2:0]  code;
    hdr = {c_MAGIC, seq, len, seed};
    if (seq != m_exp_seq)                                  code = 3'd3;
    else if (corrupt_idx >= 0 && corrupt_idx < int'(len))  code = 3'd4;
    else if (bad_csum && c_CSUM_EN)                        code = 3'd5;
    else                                                   code = 3'd0;
    m_exp_seq = seq + 16'd1;
    idle_gap(max_gap);
    send(hdr);
    @(negedge core_clk);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    @(posedge core_clk);
    #1;
    csum = hdr;
    for (int k = 0; k < int'(len); k++) begin
      if (stop_after >= 0 && k == stop_after) return;
      k16 = k[15:0];
      w = {16'(seed + k16), seq, k16, ~k16};
      if (k == corrupt_idx) w[corrupt_bit] = ~w[corrupt_bit];
      csum = csum ^ w;
      idle_gap(max_gap);
      send(w);
    end
`ifdef GT_RX_FRAME_CHECKSUM_EN
    idle_gap(max_gap);
    send(csum ^ {63'd0, bad_csum});
`endif
    expect_close(tag, code);
  endtask

  initial begin
    logic [63:0] g;
    logic [15:0] seq, len, seed;
    int          ci;

    // Reset state
    repeat (3) @(posedge core_clk);
    #1;
    check("rst_outs", {s_tready, frame_ok, frame_err, err_code, busy, frame_cnt, err_cnt},
          64'd0);
    reset = 1'b0;
    repeat (4) @(posedge core_clk);
    #1;
    check("idle_tready", 64'(s_tready), 64'd0);
    channel_up = 1'b1;
    repeat (2) @(posedge core_clk);
    #1;
    check("hdr_tready", 64'(s_tready), 64'd1);
    check("hdr_busy", 64'(busy), 64'd0);

    // Good frame, header A55A_0000_0004_1000
    send_frame("good", 16'h0000, 16'd4, 16'h1000, -1, 6'd0, 1'b0, 0, -1);
    // Payload word 2 bit 0 corrupted
    send_frame("data_err", 16'h0001, 16'd4, 16'h2000, 2, 6'd0, 1'b0, 0, -1);
    // Sequence skip; a data error in the same frame must not replace the seq code
    send_frame("seq_ok", 16'h0002, 16'd4, 16'h0033, -1, 6'd0, 1'b0, 1, -1);
    send_frame("seq_skip", 16'h0005, 16'd4, 16'h0044, 1, 6'd17, 1'b0, 1, -1);
    send_frame("seq_next", 16'h0006, 16'd4, 16'h0055, -1, 6'd0, 1'b0, 1, -1);
`ifdef GT_RX_FRAME_CHECKSUM_EN
    send_frame("csum_bad", m_exp_seq, 16'd3, 16'h0777, -1, 6'd0, 1'b1, 0, -1);
`endif

    // Bad magic, then garbage is dropped until a real header
    send({16'h1234, 16'h0009, 16'd4, 16'h0000});
    expect_close("magic", 3'd1);
    for (int i = 0; i < 3; i++) begin
      g = {$urandom, $urandom};
      if (g[63:48] == c_MAGIC) g[63:48] = ~c_MAGIC;
      send(g);
      @(negedge core_clk);
      check("resync_quiet", {62'd0, frame_ok, frame_err}, 64'd0);
      @(posedge core_clk);
      #1;
    end
    send_frame("resync_frame", m_exp_seq, 16'd4, 16'h0abc, -1, 6'd0, 1'b0, 0, -1);

    // Length boundaries
    send({c_MAGIC, m_exp_seq, 16'd0, 16'h0001});
    expect_close("len_zero", 3'd2);
    send({c_MAGIC, m_exp_seq, 16'(c_MAX_LEN + 1), 16'h0001});
    expect_close("len_over", 3'd2);
    send_frame("len_max", m_exp_seq, 16'(c_MAX_LEN), 16'hfff0, -1, 6'd0, 1'b0, 0, -1);
    send_frame("len_one", m_exp_seq, 16'd1, 16'h1234, -1, 6'd0, 1'b0, 0, -1);

    // Randomised frames
    for (int i = 0; i < 24; i++) begin
      seq  = ($urandom_range(4, 0) == 0) ? 16'($urandom) : m_exp_seq;
      len  = 16'($urandom_range(8, 1));
      seed = 16'($urandom);
      ci   = ($urandom_range(3, 0) == 0) ? int'($urandom_range(int'(len) - 1, 0)) : -1;
      send_frame("rand", seq, len, seed, ci, 6'($urandom), $urandom_range(3, 0) == 0, 2, -1);
    end

    // Stall mid-frame: nothing one cycle before the limit, error 6 at it
    send_frame("stall", m_exp_seq, 16'd4, 16'h0100, -1, 6'd0, 1'b0, 0, 2);
    repeat (c_TIMEOUT - 1) @(posedge core_clk);
    #1;
    @(negedge core_clk);
    check("to_early", {62'd0, frame_ok, frame_err}, 64'd0);
    check("to_busy_pre", 64'(busy), 64'd1);
    @(posedge core_clk);
    #1;
    expect_close("timeout", 3'd6);
    check("to_busy", 64'(busy), 64'd0);
    send_frame("after_to", m_exp_seq, 16'd2, 16'h0200, -1, 6'd0, 1'b0, 0, -1);

    // Link loss mid-payload
    send_frame("link", m_exp_seq, 16'd4, 16'h0300, -1, 6'd0, 1'b0, 0, 2);
    channel_up = 1'b0;
    @(posedge core_clk);
    #1;
    expect_close("link_loss", 3'd7);
    check("link_tready", 64'(s_tready), 64'd0);
    check("link_busy", 64'(busy), 64'd0);
    channel_up = 1'b1;
    repeat (2) @(posedge core_clk);
    #1;
    // Link loss between frames gives no pulse
    channel_up = 1'b0;
    @(posedge core_clk);
    #1;
    @(negedge core_clk);
    check("link_idle_quiet", {62'd0, frame_ok, frame_err}, 64'd0);
    check("link_idle_tready", 64'(s_tready), 64'd0);
    channel_up = 1'b1;
    repeat (2) @(posedge core_clk);
    #1;
    send_frame("after_link", m_exp_seq, 16'd3, 16'h0400, -1, 6'd0, 1'b0, 0, -1);

    // Reset mid-frame: everything clears at once, no pulse
    send_frame("rst_mid", m_exp_seq, 16'd4, 16'h0500, -1, 6'd0, 1'b0, 0, 1);
    reset = 1'b1;
    #1;
    check("rst_mid_outs",
          {s_tready, frame_ok, frame_err, err_code, busy, frame_cnt, err_cnt}, 64'd0);
    repeat (3) @(posedge core_clk);
    #1;
    reset = 1'b0;
    m_fcnt = 0;
    m_ecnt = 0;
    m_exp_seq = '0;
    repeat (4) @(posedge core_clk);
    #1;
    send_frame("post_rst", 16'h0000, 16'd4, 16'h1000, -1, 6'd0, 1'b0, 0, -1);

    repeat (3) @(posedge core_clk);
    check("pulse_count", 64'(pulses_seen), 64'(m_pulses));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
